psola_scheduler: RTL and testbench
==================================

// Module: psola_scheduler
// PURPOSE
//  Central sequencer for the per-window pitch-correction path. Counts incoming audio samples into
//  WINDOW_SIZE windows, kicks off pitch detection per full window, hands the detected period to
//  PSOLA, paces the input-buffer burst read into PSOLA, then paces output-buffer playback.
//  Sits between the sample source, the YIN detector, the input/output ring buffers and bram_wrapper.
// PARAMETERS
//  WINDOW_SIZE         2048   samples per analysis window; also burst length
//  BURST_PERIOD        5      clk cycles between successive burst read strobes (>=2)
//  SAMP_PLAY_DURATION  2304   clk cycles between output-buffer read strobes
//  TAU_TIMEOUT         65535  max cycles to wait for taumin_valid_in before abandoning window
// PORTS
//  clk_in            in   1   system clock
//  rst_in            in   1   asynchronous, active-high reset
//  sample_valid_in   in   1   one pulse per accepted input sample
//  taumin_in         in   11  detected period from YIN
//  taumin_valid_in   in   1   taumin_in valid strobe
//  psola_done_in     in   1   PSOLA finished current window
//  yin_start_out     out  1   1-cycle pulse: window complete, start pitch detection
//  tau_out           out  11  latched period for PSOLA
//  tau_valid_out     out  1   1-cycle pulse, tau_out valid
//  burst_trigger_out out  1   1-cycle read strobe to input ring buffer
//  burst_addr_out    out  11  window-relative address of current burst strobe
//  play_trigger_out  out  1   1-cycle read strobe to output ring buffer
//  busy_out          out  1   high in any state other than FILL
//  overrun_cnt_out   out  8   saturating count of dropped windows + tau timeouts
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): all outputs 0; state FILL; sample counter =
//   WINDOW_SIZE-1 so the first sample maps to index 0; primed=0; pacing counters 0.
//  Sample counter: increments on sample_valid_in, wraps WINDOW_SIZE-1 -> 0; window_full is
//   asserted internally on the cycle the counter writes WINDOW_SIZE-1.
//  FSM (states in psola_pkg::sched_state_e):
//   FILL:      window_full -> yin_start_out=1 next cycle, go WAIT_TAU, clear timeout counter.
//   WAIT_TAU:  taumin_valid_in -> tau_out<=taumin_in, tau_valid_out=1 next cycle, go BURST.
//              timeout counter == TAU_TIMEOUT-1 -> overrun_cnt++, go FILL.
//   BURST:     hold counter 0..BURST_PERIOD-1; at BURST_PERIOD-1 pulse burst_trigger_out with
//              burst_addr_out = current addr; addr 0..WINDOW_SIZE-1; after strobe at addr
//              WINDOW_SIZE-1 -> addr<=0, go WAIT_DONE. First strobe BURST_PERIOD cycles
//              after tau_valid_out.
//   WAIT_DONE: psola_done_in -> primed<=1, go FILL.
//  Simultaneous events:
//   - window_full in WAIT_TAU/BURST: window dropped, overrun_cnt++ (saturate at 255), no state change.
//   - window_full same cycle as psola_done_in in WAIT_DONE: not an overrun; go directly WAIT_TAU,
//     yin_start_out pulses next cycle.
//   - taumin_valid_in outside WAIT_TAU and psola_done_in outside WAIT_DONE: ignored.
//   - timeout and taumin_valid_in same cycle: taumin wins.
//  Playback: once primed, play counter runs continuously regardless of FSM state; pulses
//   play_trigger_out when counter == SAMP_PLAY_DURATION-1, then wraps to 0. First pulse
//   SAMP_PLAY_DURATION cycles after the psola_done_in that set primed.
//  All strobe outputs are registered single-cycle pulses; never asserted two cycles in a row.
//  Reset mid-operation aborts any burst immediately; no trailing strobes after rst_in rises.
// STRUCTURE
//  psola_pkg: sched_state_e enum, default WINDOW_SIZE/BURST_PERIOD/SAMP_PLAY_DURATION constants.
//  One sub-module: strobe_divider #(PERIOD) (enable, pulse every PERIOD cycles, clear input),
//   instanced twice: burst pacing and playback pacing.
// TESTING
//  1 reset, 2048 sample pulses -> exactly one yin_start_out, on cycle after 2048th pulse; busy_out=1.
//  2 taumin_in=11'd300 in WAIT_TAU -> tau_out=300, tau_valid_out 1 cycle later; 2048 burst strobes,
//    addr 0..2047, 5 cycles apart, first 5 cycles after tau_valid_out.
//  3 psola_done_in in WAIT_DONE -> busy_out=0; play_trigger_out every 2304 cycles, first 2304
//    cycles after done.
//  4 extra 2048 samples during BURST -> overrun_cnt_out=1, burst sequence uninterrupted.
//  5 no taumin for TAU_TIMEOUT=16 (override) -> overrun_cnt_out=1, state FILL, no tau_valid_out.
//  6 rst_in asserted at burst addr 1000 -> all outputs 0 within same cycle, no further strobes.

Source files
------------

// File: rtl/psola_pkg.sv
// psola_pkg
//   Shared types and default constants for the PSOLA window scheduler.
//   sched_state_e : scheduler FSM states
//   *_DEF         : default parameter values for psola_scheduler
//   sat_add8      : 8-bit saturating add of a 0..3 increment
package psola_pkg;

    typedef enum logic [1:0] {
        S_FILL      = 2'd0,
        S_WAIT_TAU  = 2'd1,
        S_BURST     = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int unsigned WINDOW_SIZE_DEF        = 2048;
    localparam int unsigned BURST_PERIOD_DEF       = 5;
    localparam int unsigned SAMP_PLAY_DURATION_DEF = 2304;
    localparam int unsigned TAU_TIMEOUT_DEF        = 65535;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/strobe_divider.sv
// strobe_divider
//   Free-running modulo-PERIOD counter that advances while enabled and
//   flags the last count of each period.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   en_i   : advance the counter this cycle
//   clr_i  : force the counter back to 0 (overrides en_i)
//   tick_o : combinational, high on the enabled cycle where count == PERIOD-1
module strobe_divider #(
    parameter int unsigned PERIOD = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && !clr_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/psola_scheduler.sv
// psola_scheduler
//   Per-window sequencer: counts samples into windows, starts YIN, latches the
//   period for PSOLA, paces the input-buffer burst read, then paces playback.
//   clk_in / rst_in       : clock, asynchronous active-high reset
//   sample_valid_in       : one pulse per accepted input sample
//   taumin_in/_valid_in   : period from YIN and its strobe
//   psola_done_in         : PSOLA finished the current window
//   yin_start_out         : pulse, window complete
//   tau_out/tau_valid_out : latched period and its pulse
//   burst_trigger_out     : input ring-buffer read strobe, addr on burst_addr_out
//   play_trigger_out      : output ring-buffer read strobe
//   busy_out              : FSM not in FILL
//   overrun_cnt_out       : saturating count of dropped windows and tau timeouts
module psola_scheduler
    import psola_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE        = WINDOW_SIZE_DEF,
    parameter int unsigned BURST_PERIOD       = BURST_PERIOD_DEF,
    parameter int unsigned SAMP_PLAY_DURATION = SAMP_PLAY_DURATION_DEF,
    parameter int unsigned TAU_TIMEOUT        = TAU_TIMEOUT_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_valid_in,
    input  logic [10:0] taumin_in,
    input  logic        taumin_valid_in,
    input  logic        psola_done_in,
    output logic        yin_start_out,
    output logic [10:0] tau_out,
    output logic        tau_valid_out,
    output logic        burst_trigger_out,
    output logic [10:0] burst_addr_out,
    output logic        play_trigger_out,
    output logic        busy_out,
    output logic [7:0]  overrun_cnt_out
);

    localparam logic [10:0] WS_LAST  = 11'(WINDOW_SIZE - 1);
    localparam logic [15:0] TMO_LAST = 16'(TAU_TIMEOUT - 1);

    sched_state_e state_q;
    logic [10:0]  sample_cnt_q, sample_cnt_d;
    logic [10:0]  addr_q;
    logic [15:0]  tmo_q;
    logic         primed_q;
    logic         yin_q, tau_valid_q, burst_trig_q, play_q, busy_q;
    logic [10:0]  tau_q, burst_addr_q;
    logic [7:0]   ovr_q;

    logic window_full, tmo_hit, drop_win, done_accept;
    logic burst_tick, play_tick;
    logic [1:0] ovr_inc;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (sample_valid_in) begin
            sample_cnt_d = (sample_cnt_q == WS_LAST) ? '0 : sample_cnt_q + 11'd1;
        end
    end

    assign window_full = sample_valid_in && (sample_cnt_d == WS_LAST);
    assign done_accept = (state_q == S_WAIT_DONE) && psola_done_in;
    // taumin arriving on the timeout cycle wins, so it masks the timeout
    assign tmo_hit     = (state_q == S_WAIT_TAU) && !taumin_valid_in && (tmo_q == TMO_LAST);
    // A window completing while busy is lost, except when it coincides with
    // psola_done_in: then it is handed straight to YIN.
    assign drop_win    = window_full && (state_q != S_FILL) && !done_accept;
    assign ovr_inc     = {1'b0, drop_win} + {1'b0, tmo_hit};

    strobe_divider #(.PERIOD(BURST_PERIOD)) u_burst_div (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .en_i   (state_q == S_BURST),
        .clr_i  (state_q != S_BURST),
        .tick_o (burst_tick)
    );

    // Playback counts from the done cycle itself so the first strobe lands
    // exactly SAMP_PLAY_DURATION cycles after psola_done_in.
    strobe_divider #(.PERIOD(SAMP_PLAY_DURATION)) u_play_div (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .en_i   (primed_q || done_accept),
        .clr_i  (1'b0),
        .tick_o (play_tick)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_FILL;
            sample_cnt_q <= WS_LAST;
            addr_q       <= '0;
            tmo_q        <= '0;
            primed_q     <= 1'b0;
            yin_q        <= 1'b0;
            tau_valid_q  <= 1'b0;
            burst_trig_q <= 1'b0;
            play_q       <= 1'b0;
            busy_q       <= 1'b0;
            tau_q        <= '0;
            burst_addr_q <= '0;
            ovr_q        <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            yin_q        <= 1'b0;
            tau_valid_q  <= 1'b0;
            burst_trig_q <= 1'b0;
            play_q       <= play_tick;
            ovr_q        <= sat_add8(ovr_q, ovr_inc);
            case (state_q)
                S_FILL: begin
                    if (window_full) begin
                        state_q <= S_WAIT_TAU;
                        busy_q  <= 1'b1;
                        yin_q   <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                S_WAIT_TAU: begin
                    if (taumin_valid_in) begin
                        tau_q       <= taumin_in;
                        tau_valid_q <= 1'b1;
                        state_q     <= S_BURST;
                    end else if (tmo_hit) begin
                        state_q <= S_FILL;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_BURST: begin
                    if (burst_tick) begin
                        burst_trig_q <= 1'b1;
                        burst_addr_q <= addr_q;
                        if (addr_q == WS_LAST) begin
                            addr_q  <= '0;
                            state_q <= S_WAIT_DONE;
                        end else begin
                            addr_q <= addr_q + 11'd1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (psola_done_in) begin
                        primed_q <= 1'b1;
                        if (window_full) begin
                            state_q <= S_WAIT_TAU;
                            yin_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= S_FILL;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_FILL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign yin_start_out     = yin_q;
    assign tau_out           = tau_q;
    assign tau_valid_out     = tau_valid_q;
    assign burst_trigger_out = burst_trig_q;
    assign burst_addr_out    = burst_addr_q;
    assign play_trigger_out  = play_q;
    assign busy_out          = busy_q;
    assign overrun_cnt_out   = ovr_q;

endmodule

// File: tb/tb_psola_scheduler.sv
// tb_psola_scheduler
//   Directed stimulus against psola_scheduler with an event-time reference
//   model compared every cycle, plus literal expectations per scenario.
module tb_psola_scheduler;

    localparam int WS  = 2048;
    localparam int BP  = 5;
    localparam int SPD = 2304;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sv = 1'b0, tv = 1'b0, done = 1'b0;
    logic [10:0] tau_in = '0;
    logic        yin, tauv, bt, pt, busy;
    logic [10:0] tau_o, addr;
    logic [7:0]  ovr;

    psola_scheduler #(
        .WINDOW_SIZE(WS),
        .BURST_PERIOD(BP),
        .SAMP_PLAY_DURATION(SPD),
        .TAU_TIMEOUT(TMO)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .sample_valid_in   (sv),
        .taumin_in         (tau_in),
        .taumin_valid_in   (tv),
        .psola_done_in     (done),
        .yin_start_out     (yin),
        .tau_out           (tau_o),
        .tau_valid_out     (tauv),
        .burst_trigger_out (bt),
        .burst_addr_out    (addr),
        .play_trigger_out  (pt),
        .busy_out          (busy),
        .overrun_cnt_out   (ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (event times) ----------------
    typedef enum int {M_FILL, M_WAIT, M_BURST, M_DONE} mmode_t;
    mmode_t mode = M_FILL, nmode;
    int  cyc = 0, scount = 0, wstart = 0, bt0 = 0, dcyc = 0, inc = 0, t = 0, k = 0;
    bit  primed = 0, full = 0;
    bit  e_yin = 0, e_tv = 0, e_bt = 0, e_pt = 0, e_busy = 0;
    int  e_addr = 0, e_tau = 0, e_ovr = 0;

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc = 0; scount = 0; mode = M_FILL; primed = 0;
                e_yin = 0; e_tv = 0; e_bt = 0; e_pt = 0; e_busy = 0;
                e_addr = 0; e_tau = 0; e_ovr = 0;
            end else begin
                t     = cyc + 1;
                full  = sv && (scount == WS - 1);
                if (sv) scount = (scount + 1) % WS;
                e_yin = 0; e_tv = 0; e_bt = 0; inc = 0;
                nmode = mode;
                case (mode)
                    M_FILL: if (full) begin e_yin = 1; nmode = M_WAIT; wstart = t; end
                    M_WAIT: begin
                        if (tv) begin
                            e_tau = int'(tau_in); e_tv = 1; nmode = M_BURST; bt0 = t;
                        end else if (cyc - wstart == TMO - 1) begin
                            inc++; nmode = M_FILL;
                        end
                        if (full) inc++;
                    end
                    M_BURST: begin
                        if (full) inc++;
                        k = t - bt0;
                        if (k > 0 && k % BP == 0) begin
                            e_bt = 1; e_addr = k / BP - 1;
                            if (e_addr == WS - 1) nmode = M_DONE;
                        end
                    end
                    M_DONE: begin
                        if (done) begin
                            if (!primed) begin primed = 1; dcyc = cyc; end
                            if (full) begin e_yin = 1; nmode = M_WAIT; wstart = t; end
                            else nmode = M_FILL;
                        end else if (full) begin
                            inc++;
                        end
                    end
                    default: nmode = M_FILL;
                endcase
                e_pt   = primed && (t > dcyc) && ((t - dcyc) % SPD == 0);
                e_ovr  = (e_ovr + inc > 255) ? 255 : e_ovr + inc;
                e_busy = (nmode != M_FILL);
                mode   = nmode;
                cyc    = t;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_yin", yin, 0);  chk("rst_tauv", tauv, 0);
                chk("rst_bt", bt, 0);    chk("rst_pt", pt, 0);
                chk("rst_busy", busy, 0); chk("rst_ovr", ovr, 0);
                chk("rst_tau", tau_o, 0); chk("rst_addr", addr, 0);
            end else begin
                chk("m_yin", yin, e_yin);   chk("m_tauv", tauv, e_tv);
                chk("m_bt", bt, e_bt);      chk("m_pt", pt, e_pt);
                chk("m_busy", busy, e_busy); chk("m_ovr", ovr, e_ovr);
                chk("m_tau", tau_o, e_tau); chk("m_addr", addr, e_addr);
            end
        end
    end

    // ---------------- event monitor for literal checks ----------------
    int n_yin = 0, n_tv = 0, n_bt = 0, n_pt = 0;
    int tv_cyc = 0, first_bt = -1, prev_bt = 0, gmin = 1000000, gmax = 0;
    int last_addr = -1, first_pt = -1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (yin) n_yin++;
            if (tauv) begin
                n_tv++; tv_cyc = tcyc; first_bt = -1; gmin = 1000000; gmax = 0;
            end
            if (bt) begin
                if (first_bt < 0) first_bt = tcyc;
                else begin
                    if (tcyc - prev_bt < gmin) gmin = tcyc - prev_bt;
                    if (tcyc - prev_bt > gmax) gmax = tcyc - prev_bt;
                end
                prev_bt = tcyc; n_bt++; last_addr = int'(addr);
            end
            if (pt) begin
                if (first_pt < 0) first_pt = tcyc;
                n_pt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed stimulus ----------------
    int y0, b0, p0, n0, tv0, dcyc_tb;
    bit found;

    initial begin : main
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("t1_reset_busy", busy, 0);
        chk("t1_reset_ovr", ovr, 0);
        rst = 1'b0;

        // 1: one full window -> single yin_start the cycle after the 2048th sample
        y0 = n_yin;
        sv = 1'b1;
        repeat (WS) tick();
        sv = 1'b0;
        chk("t1_yin_after_2048", yin, 1);
        chk("t1_busy", busy, 1);

        // 2: period handoff, then burst pacing
        tau_in = 11'd300; tv = 1'b1;
        tick();
        tv = 1'b0;
        chk("t2_tau_valid", tauv, 1);
        chk("t2_tau_value", tau_o, 300);
        tick();
        chk("t1_single_yin", n_yin - y0, 1);
        chk("t2_tau_valid_pulse", tauv, 0);
        b0 = n_bt;

        // 4: a whole extra window arrives mid-burst
        repeat (100) tick();
        sv = 1'b1;
        repeat (WS) tick();
        sv = 1'b0;
        tick();
        chk("t4_overrun", ovr, 1);
        chk("t4_busy", busy, 1);

        for (int i = 0; i < 12000 && (n_bt - b0) < WS; i++) tick();
        tick();
        chk("t2_strobe_count", n_bt - b0, WS);
        chk("t2_first_strobe_delay", first_bt - tv_cyc, 5);
        chk("t2_gap_min", gmin, 5);
        chk("t2_gap_max", gmax, 5);
        chk("t2_last_addr", last_addr, 2047);
        chk("t2_wait_done_busy", busy, 1);

        // 3: PSOLA done -> idle and periodic playback
        done = 1'b1; dcyc_tb = tcyc;
        tick();
        done = 1'b0;
        chk("t3_busy_idle", busy, 0);
        p0 = n_pt;
        repeat (3 * SPD + 5) tick();
        chk("t3_play_count", n_pt - p0, 3);
        chk("t3_first_play_delay", first_pt - dcyc_tb, SPD);

        // 5: no period -> timeout
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("t5_ovr_cleared", ovr, 0);
        tv0 = n_tv;
        sv = 1'b1;
        repeat (WS) tick();
        sv = 1'b0;
        chk("t5_yin", yin, 1);
        repeat (TMO + 2) tick();
        chk("t5_timeout_ovr", ovr, 1);
        chk("t5_back_to_fill", busy, 0);
        chk("t5_no_tau_valid", n_tv - tv0, 0);

        // 6: reset in the middle of a burst
        sv = 1'b1;
        repeat (WS) tick();
        sv = 1'b0;
        tau_in = 11'd77; tv = 1'b1;
        tick();
        tv = 1'b0;
        found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            tick();
            if (bt === 1'b1 && addr == 11'd1000) found = 1;
        end
        chk("t6_reached_addr1000", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_bt_cleared", bt, 0);
        chk("t6_addr_cleared", addr, 0);
        chk("t6_busy_cleared", busy, 0);
        chk("t6_tau_cleared", tau_o, 0);
        chk("t6_ovr_cleared", ovr, 0);
        n0 = n_bt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();
        chk("t6_no_trailing_strobes", n_bt - n0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
